// File: rtl/ay3891x_pkg.sv
// ay3891x_pkg: register map, stored-width masks, log volume table and envelope shape bits for the PSG
package ay3891x_pkg;
  localparam logic [3:0] R_TONE_A_FINE   = 4'd0;
  localparam logic [3:0] R_TONE_A_COARSE = 4'd1;
  localparam logic [3:0] R_TONE_B_FINE   = 4'd2;
  localparam logic [3:0] R_TONE_B_COARSE = 4'd3;
  localparam logic [3:0] R_TONE_C_FINE   = 4'd4;
  localparam logic [3:0] R_TONE_C_COARSE = 4'd5;
  localparam logic [3:0] R_NOISE         = 4'd6;
  localparam logic [3:0] R_MIXER         = 4'd7;
  localparam logic [3:0] R_AMP_A         = 4'd8;
  localparam logic [3:0] R_AMP_B         = 4'd9;
  localparam logic [3:0] R_AMP_C         = 4'd10;
  localparam logic [3:0] R_ENV_FINE      = 4'd11;
  localparam logic [3:0] R_ENV_COARSE    = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE     = 4'd13;
  localparam logic [3:0] R_IO_A          = 4'd14;
  localparam logic [3:0] R_IO_B          = 4'd15;

  localparam int ENV_HOLD = 0;
  localparam int ENV_ALT  = 1;
  localparam int ENV_ATT  = 2;
  localparam int ENV_CONT = 3;

  localparam logic [7:0] LOG_VOL [16] = '{
    8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd16,
    8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd180, 8'd255
  };

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    return (a == R_NOISE || a == R_AMP_A || a == R_AMP_B || a == R_AMP_C) ? 8'h1F :
           (a == R_TONE_A_COARSE || a == R_TONE_B_COARSE || a == R_TONE_C_COARSE ||
            a == R_ENV_SHAPE) ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/ay3891x_sdm.sv
// ay3891x_sdm: first-order delta-sigma modulator, output density = level / (2^W - 1)
module ay3891x_sdm #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level_i,
  output logic         pdm_o
);
  localparam logic [W:0] FULL = {1'b0, {W{1'b1}}};
  logic [W-1:0] acc_q, acc_d;
  logic [W:0] sum, diff;
  logic pdm_q, pdm_d;

  assign pdm_o = pdm_q;

  // accumulate the level and emit a one whenever a full scale has been collected
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, level_i};
    diff = sum - FULL;
    pdm_d = sum >= FULL;
    acc_d = pdm_d ? diff[W-1:0] : sum[W-1:0];
  end

  // accumulator and output bit
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end
endmodule

// File: rtl/ay3891x.sv
// ay3891x: AY-3-8910/8912 PSG clone with PDM outputs; define AY3891X_LOG_DAC_EN for logarithmic levels
module ay3891x
  import ay3891x_pkg::*;
#(
  parameter int CLK_DIV = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a0,
  input  logic       wr_tick,
  input  logic [7:0] wdata,
  input  logic       rd_tick,
  output logic [7:0] rdata,
  output logic [2:0] aout
);
  logic [7:0] regs_q [16];
  logic [3:0] addr_q;
  logic [7:0] rdata_q;
  logic [7:0] presc_q, presc_d;
  logic [3:0] div_q, div_d;
  logic tick, adv8, adv16;
  logic [4:0] noise_cnt_q, noise_cnt_d, noise_nxt, np;
  logic [16:0] lfsr_q, lfsr_d;
  logic [15:0] env_cnt_q, env_cnt_d, env_nxt, ep;
  logic [3:0] env_step_q, env_step_d, env_lvl;
  logic env_att_q, env_att_d, env_hold_q, env_hold_d;
  logic env_wr, env_wrap, env_end, env_stop;

  assign rdata = rdata_q;

  // address latch, masked register writes and registered reads; a write beats a read
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      addr_q <= '0;
      rdata_q <= '0;
    end else if (wr_tick) begin
      if (a0) regs_q[addr_q] <= wdata & reg_mask(addr_q);
      else addr_q <= wdata[3:0];
    end else if (rd_tick) begin
      rdata_q <= a0 ? regs_q[addr_q] : 8'h00;
    end
  end

  // master tick, /8 and /16 advances, noise LFSR and envelope stepping
  always_comb begin
    tick = presc_q == 8'(CLK_DIV - 1);
    presc_d = tick ? 8'd0 : presc_q + 8'd1;
    div_d = div_q + {3'd0, tick};
    adv8 = tick & (div_q[2:0] == 3'd7);
    adv16 = tick & (div_q == 4'hF);
    np = (regs_q[R_NOISE][4:0] == 5'd0) ? 5'd1 : regs_q[R_NOISE][4:0];
    noise_nxt = noise_cnt_q + 5'd1;
    noise_cnt_d = adv16 ? ((noise_nxt >= np) ? 5'd0 : noise_nxt) : noise_cnt_q;
    lfsr_d = (adv16 && noise_nxt >= np) ? {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]} : lfsr_q;
    ep = ({regs_q[R_ENV_COARSE], regs_q[R_ENV_FINE]} == 16'd0) ? 16'd1 :
         {regs_q[R_ENV_COARSE], regs_q[R_ENV_FINE]};
    env_nxt = env_cnt_q + 16'd1;
    env_wr = wr_tick & a0 & (addr_q == R_ENV_SHAPE);
    env_wrap = adv16 & (env_nxt >= ep) & ~env_hold_q;
    env_end = env_step_q == 4'hF;
    env_stop = ~regs_q[R_ENV_SHAPE][ENV_CONT] | regs_q[R_ENV_SHAPE][ENV_HOLD];
    env_cnt_d = env_wr ? 16'd0 : adv16 ? ((env_nxt >= ep) ? 16'd0 : env_nxt) : env_cnt_q;
    env_step_d = env_wr ? 4'd0 : (env_wrap & ~(env_end & env_stop)) ? env_step_q + 4'd1 : env_step_q;
    env_hold_d = env_wr ? 1'b0 : env_hold_q | (env_wrap & env_end & env_stop);
    env_att_d = env_wr ? wdata[ENV_ATT] :
                (env_wrap & env_end) ? (env_att_q ^ regs_q[R_ENV_SHAPE][ENV_ALT]) & regs_q[R_ENV_SHAPE][ENV_CONT] :
                env_att_q;
    env_lvl = env_att_q ? env_step_q : ~env_step_q;
  end

  // shared timebase, noise and envelope state
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      div_q <= '0;
      noise_cnt_q <= '0;
      lfsr_q <= 17'd1;
      env_cnt_q <= '0;
      env_step_q <= '0;
      env_att_q <= 1'b0;
      env_hold_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      div_q <= div_d;
      noise_cnt_q <= noise_cnt_d;
      lfsr_q <= lfsr_d;
      env_cnt_q <= env_cnt_d;
      env_step_q <= env_step_d;
      env_att_q <= env_att_d;
      env_hold_q <= env_hold_d;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [11:0] tp, cnt_q, cnt_d, cnt_nxt;
    logic tone_q, tone_d;
    logic [3:0] lvl;
    // tone counter, mixer gate and channel level
    always_comb begin
      tp = {regs_q[2*c+1][3:0], regs_q[2*c]};
      tp = (tp == 12'd0) ? 12'd1 : tp;
      cnt_nxt = cnt_q + 12'd1;
      cnt_d = adv8 ? ((cnt_nxt >= tp) ? 12'd0 : cnt_nxt) : cnt_q;
      tone_d = tone_q ^ (adv8 & (cnt_nxt >= tp));
      lvl = ((tone_q | regs_q[R_MIXER][c]) & (lfsr_q[0] | regs_q[R_MIXER][c+3])) ?
            (regs_q[R_AMP_A+c][4] ? env_lvl : regs_q[R_AMP_A+c][3:0]) : 4'd0;
    end
    // tone state
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        tone_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        tone_q <= tone_d;
      end
    end
`ifdef AY3891X_LOG_DAC_EN
    ay3891x_sdm #(.W(8)) u_sdm (.clk(clk), .reset(reset), .level_i(LOG_VOL[lvl]), .pdm_o(aout[c]));
`else
    ay3891x_sdm #(.W(4)) u_sdm (.clk(clk), .reset(reset), .level_i(lvl), .pdm_o(aout[c]));
`endif
  end
endmodule

// File: tb/tb_ay3891x.sv
// tb_ay3891x: directed checks of the PSG bus, tone, noise, envelope, DAC density and reset
module tb_ay3891x;
  logic clk = 1'b0;
  logic reset, a0, wr_tick, rd_tick;
  logic [7:0] wdata, rdata;
  logic [2:0] aout;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [3:0] ra [6] = '{4'd1, 4'd6, 4'd13, 4'd14, 4'd7, 4'd8};
  logic [7:0] rw [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'hFF, 8'hFF};
  logic [7:0] rx [6] = '{8'h0F, 8'h1F, 8'h0F, 8'hA5, 8'hFF, 8'h1F};
  logic [16:0] lf;

  ay3891x #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .a0(a0), .wr_tick(wr_tick), .wdata(wdata),
    .rd_tick(rd_tick), .rdata(rdata), .aout(aout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic a, input logic w, input logic r, input logic [7:0] d);
    a0 = a; wr_tick = w; rd_tick = r; wdata = d;
    @(posedge clk); #1;
    wr_tick = 1'b0; rd_tick = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    bus(1'b0, 1'b1, 1'b0, {4'h0, a});
    bus(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic rd_reg(input logic [3:0] a);
    bus(1'b0, 1'b1, 1'b0, {4'h0, a});
    bus(1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic run_len(input int ch, input logic v, output int n);
    n = 0;
    while (aout[ch] === v && n < 10000) begin n++; @(posedge clk); #1; end
  endtask

  task automatic tone_check(input string tag, input int ch, input int exp);
    int n;
    run_len(ch, 1'b0, n);
    run_len(ch, 1'b1, n);
    run_len(ch, 1'b0, n);
    chk({tag, "_low"}, n, exp);
    run_len(ch, 1'b1, n);
    chk({tag, "_high"}, n, exp);
  endtask

  task automatic env_setup(input logic [7:0] shape);
    do_reset;
    wr_reg(4'd7, 8'hFF);
    wr_reg(4'd8, 8'h10);
    wr_reg(4'd11, 8'h02);
    wr_reg(4'd12, 8'h00);
    wr_reg(4'd13, shape);
  endtask

  task automatic env_chk(input logic [7:0] shape, input int k, input int exp);
    int n = 0;
    wait_cyc(64 * k + 21);
    for (int j = 0; j < 15; j++) begin
      n += int'(aout[0]);
      @(posedge clk); #1;
    end
    chk($sformatf("env_s%0h_k%0d", shape, k), n, exp);
  endtask

  initial begin
    reset = 1'b1; a0 = 1'b0; wr_tick = 1'b0; rd_tick = 1'b0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_aout", aout, 3'b000);
    chk("reset_rdata", rdata, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_reg(i[3:0]);
      chk($sformatf("reset_R%0d", i), rdata, 8'h00);
    end
    for (int i = 0; i < 6; i++) wr_reg(ra[i], rw[i]);
    for (int i = 0; i < 6; i++) begin
      rd_reg(ra[i]);
      chk($sformatf("mask_R%0d", ra[i]), rdata, rx[i]);
    end
    bus(1'b0, 1'b0, 1'b1, 8'h00);
    chk("read_a0_0", rdata, 8'h00);
    bus(1'b0, 1'b1, 1'b0, 8'hF1);
    bus(1'b1, 1'b1, 1'b0, 8'h03);
    bus(1'b1, 1'b0, 1'b1, 8'h00);
    chk("addr_hi_ignored", rdata, 8'h03);
    bus(1'b1, 1'b1, 1'b1, 8'h07);
    chk("wr_rd_collide", rdata, 8'h03);
    bus(1'b1, 1'b0, 1'b1, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("rdata_hold", rdata, 8'h07);

    do_reset;
    wr_reg(4'd7, 8'hFE);
    wr_reg(4'd0, 8'h05);
    wr_reg(4'd1, 8'h00);
    wr_reg(4'd8, 8'h0F);
    tone_check("toneA_tp5", 0, 80);
    wr_reg(4'd0, 8'h00);
    tone_check("toneA_tp0", 0, 16);
    wr_reg(4'd0, 8'h02);
    wr_reg(4'd1, 8'h01);
    tone_check("toneA_tp102", 0, 4128);
    wr_reg(4'd7, 8'hFC);
    wr_reg(4'd2, 8'h03);
    wr_reg(4'd9, 8'h0F);
    tone_check("toneB_tp3", 1, 48);

    do_reset;
    wr_reg(4'd8, 8'h0F);
    wr_reg(4'd7, 8'hF7);
    wr_reg(4'd6, 8'h01);
    lf = 17'd1;
    for (int k = 0; k < 48; k++) begin
      wait_cyc(32 * k + 17);
      chk($sformatf("noise_k%0d", k), aout[0], lf[0]);
      lf = {lf[0] ^ lf[3], lf[16:1]};
    end

    env_setup(8'h02);
    env_chk(8'h02, 0, 15);
    env_chk(8'h02, 5, 10);
    env_chk(8'h02, 15, 0);
    env_chk(8'h02, 16, 0);
    env_chk(8'h02, 18, 0);
    env_setup(8'h0B);
    env_chk(8'h0B, 1, 14);
    env_chk(8'h0B, 16, 15);
    env_chk(8'h0B, 18, 15);
    env_setup(8'h0A);
    env_chk(8'h0A, 15, 0);
    env_chk(8'h0A, 16, 0);
    env_chk(8'h0A, 17, 1);
    env_chk(8'h0A, 20, 4);
    env_setup(8'h0D);
    env_chk(8'h0D, 3, 3);
    env_chk(8'h0D, 16, 15);
    env_chk(8'h0D, 17, 15);
    env_setup(8'h04);
    env_chk(8'h04, 2, 2);
    env_chk(8'h04, 16, 0);
    env_setup(8'h08);
    env_chk(8'h08, 7, 8);
    env_chk(8'h08, 16, 15);

    do_reset;
    wr_reg(4'd7, 8'hFF);
    wr_reg(4'd8, 8'h0F);
    wr_reg(4'd9, 8'h10);
    wr_reg(4'd13, 8'h0E);
    wr_reg(4'd0, 8'h55);
    rd_reg(4'd0);
    wait_cyc(600);
    chk("pre_reset_aout0", aout[0], 1'b1);
    chk("pre_reset_rdata", rdata, 8'h55);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_aout", aout, 3'b000);
    chk("mid_reset_rdata", rdata, 8'h00);
    reset = 1'b0;
    bus(1'b1, 1'b0, 1'b1, 8'h00);
    chk("mid_reset_addr0_R0", rdata, 8'h00);
    rd_reg(4'd13);
    chk("mid_reset_R13", rdata, 8'h00);
    rd_reg(4'd8);
    chk("mid_reset_R8", rdata, 8'h00);
    chk("mid_reset_aout_after", aout, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
